keymap_load_ctrl: RTL and testbench
===================================

KEYMAP_LOAD_CTRL -- requirements
Module: keymap_load_ctrl

Interface
REQ-001 The block SHALL have parameter STROBE_CYC, default 4, giving the number of cycles each keymap-port strobe is held high.
REQ-002 The block SHALL have parameter GAP_CYC, default 2, giving the number of low cycles after each strobe before the next operation.
REQ-003 The block SHALL have parameter MAP_BYTES, default 4096, giving the number of bytes in one boot load.
REQ-004 The block SHALL have port clk, input, 1 bit, the system clock.
REQ-005 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-006 The block SHALL have port boot_start, input, 1 bit, a one-cycle pulse that requests a full keymap load.
REQ-007 The block SHALL have ports boot_valid (input, 1 bit), boot_data (input, 8 bits) and boot_ready (output, 1 bit), forming the boot byte stream handshake.
REQ-008 The block SHALL have ports boot_active (output, 1 bit) and boot_done (output, 1 bit, sticky) reporting load status.
REQ-009 The block SHALL have ports cpu_rewind_req, cpu_wr_req and cpu_rd_req, each an input of 1 bit and a one-cycle pulse.
REQ-010 The block SHALL have port cpu_wdata, input, 8 bits, carrying the CPU write data.
REQ-011 The block SHALL have ports cpu_rdata (output, 8 bits), cpu_rdata_valid (output, 1 bit, pulse), cpu_busy (output, 1 bit) and cpu_overrun (output, 1 bit, sticky).
REQ-012 The block SHALL have ports km_rewind, km_write and km_read, each an output of 1 bit, as the keymap-port strobes.
REQ-013 The block SHALL have port km_din, output, 8 bits, and port km_dout, input, 8 bits, as the keymap-port data.
REQ-014 The block SHALL have port byte_count, output, 13 bits, giving the number of boot bytes written.

Function
REQ-015 The block SHALL assert at most one of km_rewind, km_write or km_read in any cycle.
REQ-016 The block SHALL hold each strobe high for exactly STROBE_CYC consecutive cycles, then low for exactly GAP_CYC cycles.
REQ-017 The block SHALL keep km_din stable from the first strobe cycle through the last gap cycle.
REQ-018 The FSM SHALL have states IDLE, STROBE and GAP for a single operation, and BWAIT and BFIN for the boot sequence.
REQ-019 In IDLE, a pending boot request SHALL be served before a pending CPU request.
REQ-020 On boot start, the block SHALL set boot_active to 1, clear boot_done and byte_count, and issue one km_rewind operation.
REQ-021 The block SHALL then enter BWAIT with boot_ready at 1.
REQ-022 In BWAIT, a byte SHALL be accepted in the cycle where boot_valid and boot_ready are both 1.
REQ-023 On acceptance, the block SHALL drop boot_ready the next cycle, latch boot_data into km_din, issue a km_write operation, and increment byte_count after the gap.
REQ-024 When byte_count reaches MAP_BYTES, the block SHALL enter BFIN.
REQ-025 BFIN SHALL issue one km_rewind operation, then clear boot_active, set boot_done and return to IDLE.
REQ-026 boot_ready SHALL be 1 only in BWAIT.
REQ-027 The boot_valid input SHALL be ignored outside BWAIT, and no accepted byte shall be lost.
REQ-028 A boot_start pulse arriving while a CPU operation is in STROBE or GAP SHALL be latched and the boot started once that operation completes.
REQ-029 A boot_start pulse arriving while boot_active is 1 SHALL be ignored.
REQ-030 The CPU path SHALL have a one-deep pending slot holding the operation type and cpu_wdata.
REQ-031 cpu_busy SHALL be 1 while the slot is occupied or an operation is in progress on the CPU's behalf.
REQ-032 A CPU request pulse while cpu_busy is 1, or while boot_active is 1 with the slot full, SHALL be dropped and set cpu_overrun.
REQ-033 When two or more cpu_*_req pulses arrive in the same cycle, the block SHALL take rewind, then write, then read in that priority order, and set cpu_overrun.
REQ-034 A CPU request during boot SHALL occupy the slot and be served after BFIN completes.
REQ-035 For a CPU read, the block SHALL sample km_dout into cpu_rdata on the last GAP cycle and pulse cpu_rdata_valid on the following cycle, as cpu_busy falls.
REQ-036 Single-operation latency SHALL be as follows: a request in cycle 0 in IDLE gives strobe high in cycles 1..STROBE_CYC and cpu_busy low in cycle STROBE_CYC+GAP_CYC+1.
REQ-037 byte_count SHALL saturate at MAP_BYTES and SHALL NOT wrap.

Reset
REQ-038 On rst, the block SHALL enter IDLE within one cycle, even mid-strobe, and deassert all strobes.
REQ-039 On rst, boot_ready, boot_active, boot_done, cpu_busy, cpu_overrun, cpu_rdata_valid and byte_count SHALL be 0.
REQ-040 On rst, cpu_rdata and km_din SHALL be 8'h00.
REQ-041 On rst, the pending slot and the latched boot request SHALL be cleared.

Verification
REQ-042 The bench SHALL cover: cpu_wr_req with cpu_wdata=8'hA5 in IDLE -> km_write high cycles 1-4 with km_din=8'hA5, cpu_busy low at cycle 7.
REQ-043 The bench SHALL cover: cpu_rd_req with km_dout=8'h3C -> cpu_rdata=8'h3C, a cpu_rdata_valid pulse at cycle 7, and no km_write.
REQ-044 The bench SHALL cover: boot_start with boot_valid tied to 1 and MAP_BYTES=4096 -> 1 rewind, 4096 writes, 1 rewind, byte_count=4096, boot_done=1, boot_active=0.
REQ-045 The bench SHALL cover: cpu_wr_req mid-boot, then a second cpu_rd_req mid-boot -> the write is served after BFIN, the read is dropped, and cpu_overrun=1.
REQ-046 The bench SHALL cover: boot_start during a CPU write -> the write completes unaltered, then the boot rewind starts in the next IDLE cycle.
REQ-047 The bench SHALL cover: rst asserted in the 2nd cycle of km_write -> all strobes are 0 in the next cycle and all outputs are at reset values.

Source files
------------

// File: rtl/keymap_load_ctrl.sv
// Keymap-port sequencer: serialises boot loads and CPU rewind/write/read
// requests onto timed strobes, with a one-deep CPU slot held across a boot.
module keymap_load_ctrl #(
  parameter int STROBE_CYC = 4,
  parameter int GAP_CYC    = 2,
  parameter int MAP_BYTES  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        boot_start,
  input  logic        boot_valid,
  input  logic [7:0]  boot_data,
  output logic        boot_ready,
  output logic        boot_active,
  output logic        boot_done,
  input  logic        cpu_rewind_req,
  input  logic        cpu_wr_req,
  input  logic        cpu_rd_req,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdata_valid,
  output logic        cpu_busy,
  output logic        cpu_overrun,
  output logic        km_rewind,
  output logic        km_write,
  output logic        km_read,
  output logic [7:0]  km_din,
  input  logic [7:0]  km_dout,
  output logic [12:0] byte_count
);

  localparam int CMAX = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, STROBE, GAP, BWAIT, BFIN} state_t;
  typedef enum logic [1:0] {OP_RW, OP_WR, OP_RD} op_t;
  typedef enum logic [1:0] {SRC_CPU, SRC_BSTART, SRC_BWR, SRC_BFIN} src_t;

  state_t        state;
  logic [CW-1:0] cnt;
  op_t           cur_op;
  src_t          cur_src;
  logic          slot_vld;
  op_t           slot_op;
  logic [7:0]    slot_data;
  logic          cpu_inflight;
  logic          boot_pend;

  logic       any_req, multi_req, new_ok, boot_go, slot_load, slot_take, launch;
  op_t        new_op, l_op;
  src_t       l_src;
  logic [7:0] l_din;

  assign cpu_busy  = slot_vld | cpu_inflight;
  assign any_req   = cpu_rewind_req | cpu_wr_req | cpu_rd_req;
  assign multi_req = (cpu_rewind_req & cpu_wr_req) | (cpu_rewind_req & cpu_rd_req) |
                     (cpu_wr_req & cpu_rd_req);
  // A full slot always implies busy, so busy alone gates new CPU requests.
  assign new_ok    = any_req & ~cpu_busy;
  assign boot_go   = (state == IDLE) & (boot_start | boot_pend);
  assign slot_load = new_ok & ~((state == IDLE) & ~boot_go);

  always_comb begin
    new_op = OP_RD;
    if (cpu_wr_req)     new_op = OP_WR;
    if (cpu_rewind_req) new_op = OP_RW;
  end

  always_comb begin
    launch    = 1'b0;
    l_op      = OP_RW;
    l_src     = SRC_CPU;
    l_din     = km_din;
    slot_take = 1'b0;
    case (state)
      IDLE: begin
        if (boot_go) begin
          launch = 1'b1;
          l_src  = SRC_BSTART;
        end else if (slot_vld) begin
          launch    = 1'b1;
          l_op      = slot_op;
          slot_take = 1'b1;
          if (slot_op == OP_WR) l_din = slot_data;
        end else if (new_ok) begin
          launch = 1'b1;
          l_op   = new_op;
          if (new_op == OP_WR) l_din = cpu_wdata;
        end
      end
      BWAIT: begin
        if (boot_valid && boot_ready) begin
          launch = 1'b1;
          l_op   = OP_WR;
          l_src  = SRC_BWR;
          l_din  = boot_data;
        end
      end
      BFIN: begin
        launch = 1'b1;
        l_src  = SRC_BFIN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      cur_op          <= OP_RW;
      cur_src         <= SRC_CPU;
      slot_vld        <= 1'b0;
      slot_op         <= OP_RW;
      slot_data       <= 8'h00;
      cpu_inflight    <= 1'b0;
      boot_pend       <= 1'b0;
      boot_ready      <= 1'b0;
      boot_active     <= 1'b0;
      boot_done       <= 1'b0;
      cpu_rdata       <= 8'h00;
      cpu_rdata_valid <= 1'b0;
      cpu_overrun     <= 1'b0;
      km_rewind       <= 1'b0;
      km_write        <= 1'b0;
      km_read         <= 1'b0;
      km_din          <= 8'h00;
      byte_count      <= '0;
    end else begin
      cpu_rdata_valid <= 1'b0;
      if (any_req && (cpu_busy || multi_req)) cpu_overrun <= 1'b1;

      if (slot_load) begin
        slot_vld  <= 1'b1;
        slot_op   <= new_op;
        slot_data <= cpu_wdata;
      end else if (slot_take) begin
        slot_vld <= 1'b0;
      end

      if (boot_go)
        boot_pend <= 1'b0;
      else if (boot_start && !boot_active && (state == STROBE || state == GAP))
        boot_pend <= 1'b1;

      if (launch) begin
        state      <= STROBE;
        cnt        <= CW'(STROBE_CYC - 1);
        km_rewind  <= (l_op == OP_RW);
        km_write   <= (l_op == OP_WR);
        km_read    <= (l_op == OP_RD);
        km_din     <= l_din;
        cur_op     <= l_op;
        cur_src    <= l_src;
        boot_ready <= 1'b0;
        if (l_src == SRC_CPU) cpu_inflight <= 1'b1;
        if (l_src == SRC_BSTART) begin
          boot_active <= 1'b1;
          boot_done   <= 1'b0;
          byte_count  <= '0;
        end
      end else begin
        case (state)
          STROBE: begin
            if (cnt == '0) begin
              km_rewind <= 1'b0;
              km_write  <= 1'b0;
              km_read   <= 1'b0;
              state     <= GAP;
              cnt       <= CW'(GAP_CYC - 1);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          GAP: begin
            if (cnt == '0) begin
              case (cur_src)
                SRC_CPU: begin
                  cpu_inflight <= 1'b0;
                  if (cur_op == OP_RD) begin
                    cpu_rdata       <= km_dout;
                    cpu_rdata_valid <= 1'b1;
                  end
                  state <= IDLE;
                end
                SRC_BSTART: begin
                  state      <= BWAIT;
                  boot_ready <= 1'b1;
                end
                SRC_BWR: begin
                  if (byte_count != 13'(MAP_BYTES)) byte_count <= byte_count + 1'b1;
                  if (int'(byte_count) + 1 >= MAP_BYTES) begin
                    state <= BFIN;
                  end else begin
                    state      <= BWAIT;
                    boot_ready <= 1'b1;
                  end
                end
                default: begin
                  boot_active <= 1'b0;
                  boot_done   <= 1'b1;
                  state       <= IDLE;
                end
              endcase
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keymap_load_ctrl.sv
// Bench for keymap_load_ctrl: expected strobe operations, read data and busy
// windows come from a queue-based model of the request/boot rules.
module tb_keymap_load_ctrl;
  localparam int S  = 4;
  localparam int G  = 2;
  localparam int MB = 4096;

  logic        clk, rst;
  logic        boot_start, boot_valid, boot_ready, boot_active, boot_done;
  logic [7:0]  boot_data;
  logic        cpu_rewind_req, cpu_wr_req, cpu_rd_req;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_rdata_valid, cpu_busy, cpu_overrun;
  logic        km_rewind, km_write, km_read;
  logic [7:0]  km_din, km_dout;
  logic [12:0] byte_count;

  keymap_load_ctrl #(.STROBE_CYC(S), .GAP_CYC(G), .MAP_BYTES(MB)) dut (
    .clk(clk), .rst(rst), .boot_start(boot_start), .boot_valid(boot_valid),
    .boot_data(boot_data), .boot_ready(boot_ready), .boot_active(boot_active),
    .boot_done(boot_done), .cpu_rewind_req(cpu_rewind_req), .cpu_wr_req(cpu_wr_req),
    .cpu_rd_req(cpu_rd_req), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_rdata_valid(cpu_rdata_valid), .cpu_busy(cpu_busy), .cpu_overrun(cpu_overrun),
    .km_rewind(km_rewind), .km_write(km_write), .km_read(km_read), .km_din(km_din),
    .km_dout(km_dout), .byte_count(byte_count)
  );

  typedef struct {int op; logic [7:0] din; bit cd;} kop_t;  // op: 0 rewind, 1 write, 2 read

  kop_t       exp_q[$];
  kop_t       defer_q[$];
  logic [7:0] rd_exp[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int n_rw = 0, n_wr = 0, n_rd = 0;
  int acc_c = -100, free_c = 0;
  bit chk_busy = 0, ovr_exp = 0;
  bit bsrc_en = 0, bsrc_rand = 0;
  int bacc = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_strobes", {km_rewind, km_write, km_read}, 0);
    chk("rst_boot_flags", {boot_ready, boot_active, boot_done}, 0);
    chk("rst_cpu_flags", {cpu_busy, cpu_overrun, cpu_rdata_valid}, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);
    chk("rst_km_din", km_din, 8'h00);
  endtask

  // Boot byte source: one expected write per accepted byte; the closing rewind
  // and any CPU ops parked during the boot follow the last byte.
  initial begin
    bit acc;
    boot_valid = 0;
    boot_data  = 8'h00;
    forever begin
      @(negedge clk);
      acc = boot_valid && boot_ready && !rst;
      tick();
      if (acc) begin
        exp_q.push_back('{1, boot_data, 1'b1});
        bacc++;
        boot_data = 8'($urandom);
        if (bacc == MB) begin
          exp_q.push_back('{0, 8'h00, 1'b0});
          while (defer_q.size() > 0) exp_q.push_back(defer_q.pop_front());
          bsrc_en = 0;
        end
      end
      boot_valid = bsrc_en && (!bsrc_rand || $urandom_range(0, 3) != 0);
    end
  end

  // Per-cycle compare: strobe shape, op sequence, km_din hold, busy, read data.
  initial begin
    int hi_len, lo_len, din_left, opi;
    logic [2:0] s, cur_s;
    logic [7:0] din0;
    kop_t e;
    hi_len = 0; lo_len = 100; din_left = 0; cur_s = 0; din0 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hi_len = 0; lo_len = 100; din_left = 0;
      end else begin
        s = {km_read, km_write, km_rewind};
        chk("strobe_onehot", $onehot0(s), 1);
        if (s != 0) begin
          if (hi_len == 0) begin
            chk("gap_min", lo_len >= G, 1);
            opi = s[0] ? 0 : (s[1] ? 1 : 2);
            if (opi == 0) n_rw++; else if (opi == 1) n_wr++; else n_rd++;
            if (exp_q.size() == 0) chk("op_unexpected", opi, 99);
            else begin
              e = exp_q.pop_front();
              chk("op_kind", opi, e.op);
              if (e.cd) chk("op_din", km_din, e.din);
            end
            cur_s = s; din0 = km_din; din_left = S + G;
          end else begin
            chk("strobe_kind", s, cur_s);
          end
          hi_len++; lo_len = 0;
        end else begin
          if (hi_len != 0) chk("strobe_len", hi_len, S);
          hi_len = 0; lo_len++;
        end
        if (din_left > 0) begin
          chk("din_stable", km_din, din0);
          din_left--;
        end
        if (chk_busy) chk("cpu_busy", cpu_busy, (cyc > acc_c) && (cyc < free_c));
        if (cpu_rdata_valid) begin
          if (rd_exp.size() == 0) chk("rdata_unexpected", 1, 0);
          else chk("cpu_rdata", cpu_rdata, rd_exp.pop_front());
        end
      end
    end
  end

  initial begin
    int rw0, wr0, rd0, r;
    logic [2:0] m;
    logic [7:0] x, y;
    rst = 1; boot_start = 0; cpu_rewind_req = 0; cpu_wr_req = 0; cpu_rd_req = 0;
    cpu_wdata = 0; km_dout = 0;
    repeat (3) tick();
    @(negedge clk);
    chk_reset_vals();
    tick(); rst = 0;
    repeat (2) tick();

    // CPU write A5: strobe cycles 1-4, busy low at cycle 7
    cpu_wr_req = 1; cpu_wdata = 8'hA5;
    exp_q.push_back('{1, 8'hA5, 1'b1});
    for (int k = 1; k <= 7; k++) begin
      tick(); cpu_wr_req = 0;
      @(negedge clk);
      chk("wr_strobe", km_write, k <= S);
      if (k <= S + G) chk("wr_din", km_din, 8'hA5);
      chk("wr_busy", cpu_busy, k <= S + G);
    end

    // CPU read with km_dout 3C: valid pulse at cycle 7
    tick(); cpu_rd_req = 1; km_dout = 8'h3C;
    exp_q.push_back('{2, 8'h00, 1'b0});
    rd_exp.push_back(8'h3C);
    for (int k = 1; k <= 7; k++) begin
      tick(); cpu_rd_req = 0;
      @(negedge clk);
      chk("rd_strobe", km_read, k <= S);
      chk("rd_no_write", km_write, 0);
      chk("rd_valid", cpu_rdata_valid, k == 7);
      if (k == 7) chk("rd_data", cpu_rdata, 8'h3C);
    end
    chk("overrun_clean", cpu_overrun, 0);

    // Random CPU traffic outside boot
    tick();
    chk_busy = 1; acc_c = -100; free_c = 0; ovr_exp = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      cpu_rewind_req = 0; cpu_wr_req = 0; cpu_rd_req = 0;
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 15);
        m = (r < 12) ? 3'(1 << (r % 3)) : 3'($urandom_range(1, 7));
        cpu_wdata = 8'($urandom);
        if (cyc >= free_c) begin
          r = m[0] ? 0 : (m[1] ? 1 : 2);
          if (r == 2) begin
            km_dout = 8'($urandom);
            rd_exp.push_back(km_dout);
          end
          exp_q.push_back('{r, cpu_wdata, r == 1});
          acc_c = cyc; free_c = cyc + S + G + 1;
          if ($countones(m) > 1) ovr_exp = 1;
        end else begin
          ovr_exp = 1;
        end
        cpu_rewind_req = m[0]; cpu_wr_req = m[1]; cpu_rd_req = m[2];
      end
    end
    tick();
    cpu_rewind_req = 0; cpu_wr_req = 0; cpu_rd_req = 0;
    repeat (10) tick();
    chk_busy = 0;
    @(negedge clk);
    chk("rand_overrun", cpu_overrun, ovr_exp);
    chk("rand_ops_left", exp_q.size(), 0);
    chk("rand_reads_left", rd_exp.size(), 0);

    // Reset in the 2nd write-strobe cycle
    tick(); cpu_wr_req = 1; cpu_wdata = 8'hB7;
    exp_q.push_back('{1, 8'hB7, 1'b1});
    tick(); cpu_wr_req = 0;
    tick(); rst = 1;
    @(negedge clk);
    chk("pre_rst_write", km_write, 1);
    tick();
    @(negedge clk);
    chk_reset_vals();
    tick(); rst = 0;
    repeat (5) tick();

    // Full boot with boot_valid held high
    rw0 = n_rw; wr0 = n_wr;
    boot_start = 1; bacc = 0; bsrc_rand = 0; bsrc_en = 1;
    exp_q.push_back('{0, 8'h00, 1'b0});
    tick(); boot_start = 0;
    @(negedge clk);
    chk("boot_rewind", km_rewind, 1);
    chk("boot_active_set", boot_active, 1);
    chk("boot_count_clr", byte_count, 0);
    for (int i = 0; i < 40000 && !boot_done; i++) tick();
    @(negedge clk);
    chk("boot_done", boot_done, 1);
    chk("boot_active_clr", boot_active, 0);
    chk("boot_bytes", byte_count, MB);
    chk("boot_rewinds", n_rw - rw0, 2);
    chk("boot_writes", n_wr - wr0, MB);
    chk("boot_ops_left", exp_q.size(), 0);
    repeat (3) tick();

    // Boot requested during a CPU write, then CPU traffic mid-boot
    rw0 = n_rw; wr0 = n_wr; rd0 = n_rd;
    x = 8'($urandom);
    cpu_wr_req = 1; cpu_wdata = x;
    exp_q.push_back('{1, x, 1'b1});
    for (int k = 1; k <= 8; k++) begin
      tick(); cpu_wr_req = 0;
      if (k == 2) begin
        boot_start = 1; bacc = 0; bsrc_rand = 1; bsrc_en = 1;
        exp_q.push_back('{0, 8'h00, 1'b0});
      end
      if (k == 3) boot_start = 0;
      @(negedge clk);
      chk("mix_write", km_write, k <= S);
      if (k <= S + G) chk("mix_din", km_din, x);
      if (k == 7) begin
        chk("mix_idle_rewind", km_rewind, 0);
        chk("mix_idle_active", boot_active, 0);
        chk("mix_idle_busy", cpu_busy, 0);
      end
      if (k == 8) begin
        chk("mix_boot_rewind", km_rewind, 1);
        chk("mix_boot_active", boot_active, 1);
      end
    end
    for (int i = 0; i < 2000 && bacc < 50; i++) tick();
    repeat ($urandom_range(0, 6)) tick();
    y = 8'($urandom);
    cpu_wr_req = 1; cpu_wdata = y;
    defer_q.push_back('{1, y, 1'b1});
    tick(); cpu_wr_req = 0;
    @(negedge clk);
    chk("mid_busy", cpu_busy, 1);
    chk("mid_no_overrun", cpu_overrun, 0);
    repeat (20) tick();
    cpu_rd_req = 1;
    tick(); cpu_rd_req = 0;
    @(negedge clk);
    chk("mid_overrun", cpu_overrun, 1);
    for (int i = 0; i < 40000 && !boot_done; i++) tick();
    for (int i = 0; i < 50 && cpu_busy; i++) tick();
    @(negedge clk);
    chk("mix_done", boot_done, 1);
    chk("mix_active_clr", boot_active, 0);
    chk("mix_bytes", byte_count, MB);
    chk("mix_overrun", cpu_overrun, 1);
    chk("mix_busy_clr", cpu_busy, 0);
    chk("mix_rewinds", n_rw - rw0, 2);
    chk("mix_writes", n_wr - wr0, MB + 2);
    chk("mix_reads", n_rd - rd0, 0);
    chk("mix_ops_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
